// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: two-requester write arbiter for framebuffer port A, with an
// optional full-framebuffer clear sequencer.
//
// Requester 0 (control module) has fixed priority over requester 1 (secondary
// writer). Requester 1 is not starved: after STARVE_LIMIT consecutive
// requester-0 grants taken while requester 1 waits, requester 1 wins the next
// contested cycle. Acks are combinational. An accepted payload reaches the
// registered RAM drive one cycle later.
//
// Build option: define FB_CLEAR_EN to include the CLEAR state. In CLEAR, every
// address from 0 up to all-ones is written with zero in ascending order,
// one per cycle. Without FB_CLEAR_EN, clear_start is ignored and clear_busy
// is tied low.
//
// Ports:
//   clk_in, reset           clock, asynchronous active-low reset
//   req0/addr0/data0/ack0   requester 0 write handshake
//   req1/addr1/data1/ack1   requester 1 write handshake
//   clear_start             single-cycle pulse that starts a full clear
//   clear_busy              high while the clear sequence runs
//   ram_address, ram_data_out, ram_write_enable, ram_clk_enable
//                           registered port-A drive
module fb_write_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter logic [3:0]  STARVE_LIMIT = 4'd8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ack0,
  output logic                  ack1,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable
);

  logic                  arb_en;    // requester arbitration allowed this cycle
  logic                  clr_wr;    // clear write issued this cycle
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef FB_CLEAR_EN
  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_last;

  assign clr_last = &clr_cnt_q;
  assign clr_addr = clr_cnt_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // clear_start is not looked at in StClear, so a repeat pulse neither
  // restarts nor extends the sequence.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (clear_start) state_d = StClear;
      end
      StClear: begin
        // Stop on all-ones rather than wrapping into a second pass.
        if (clr_last) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arb_en     = (state_q == StIdle);
    clr_wr     = (state_q == StClear);
    clear_busy = (state_q == StClear);
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign arb_en             = 1'b1;
  assign clr_wr             = 1'b0;
  assign clr_addr           = '0;
  assign clear_busy         = 1'b0;
`endif

  // Arbitration
  logic [3:0] starve_q, starve_d;
  logic       force1, grant0, grant1;

  // Requester 1 wins when uncontested or once its wait reaches the limit.
  assign force1 = req1 & (~req0 | (starve_q == STARVE_LIMIT));
  assign grant1 = arb_en & force1;
  assign grant0 = arb_en & req0 & ~force1;

  // Gated by reset so the acks read zero while reset is held low.
  assign ack0 = reset & grant0;
  assign ack1 = reset & grant1;

  always_comb begin
    starve_d = starve_q;
    if (!req1 || grant1) begin
      starve_d = '0;
    end else if (grant0) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Registered port-A drive
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    if (grant0) begin
      ram_addr_d = addr0;
      ram_data_d = data0;
      ram_we_d   = 1'b1;
    end else if (grant1) begin
      ram_addr_d = addr1;
      ram_data_d = data1;
      ram_we_d   = 1'b1;
    end else if (clr_wr) begin
      ram_addr_d = clr_addr;
      ram_data_d = '0;
      ram_we_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      starve_q   <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign ram_address      = ram_addr_q;
  assign ram_data_out     = ram_data_q;
  assign ram_write_enable = ram_we_q;
  assign ram_clk_enable   = ram_we_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter (default parameters). The reference
// model tracks the last committed RAM write and how many requester-0 wins
// requester 1 has waited through. The clear scenarios are built when
// FB_CLEAR_EN is defined. Otherwise the bench checks that clear_start has no effect.
module tb_fb_write_arbiter;

  localparam int Limit = 8;

  logic        clk_in;
  logic        reset;
  logic        req0, req1;
  logic [11:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1;
  logic        clear_start;
  logic        clear_busy;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable;
  logic        ram_clk_enable;

  fb_write_arbiter dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .req0            (req0),
    .req1            (req1),
    .addr0           (addr0),
    .addr1           (addr1),
    .data0           (data0),
    .data1           (data1),
    .ack0            (ack0),
    .ack1            (ack1),
    .clear_start     (clear_start),
    .clear_busy      (clear_busy),
    .ram_address     (ram_address),
    .ram_data_out    (ram_data_out),
    .ram_write_enable(ram_write_enable),
    .ram_clk_enable  (ram_clk_enable)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Reference model
  int          m_wait;    // requester-0 wins that requester 1 has waited through
  logic [11:0] m_addr;
  logic [7:0]  m_data;
  logic        m_we;
  logic        exp_ack0, exp_ack1;
  logic        obs_ack0, obs_ack1, obs_busy;

  task automatic model_reset();
    m_wait = 0;
    m_addr = '0;
    m_data = '0;
    m_we   = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample the combinational acks mid-cycle,
  // predict the winner, then advance the model past the edge.
  // 'blocked' marks cycles where no requester may be granted.
  task automatic cycle(input logic r0, input logic r1, input logic [11:0] a0,
                       input logic [11:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                       input logic cs, input logic blocked);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; data0 = d0; data1 = d1;
    clear_start = cs;
    #4;
    obs_ack0 = ack0;
    obs_ack1 = ack1;
    obs_busy = clear_busy;
    if (blocked) begin
      exp_ack0 = 1'b0;
      exp_ack1 = 1'b0;
    end else begin
      exp_ack1 = r1 && (!r0 || m_wait == Limit);
      exp_ack0 = r0 && !exp_ack1;
    end
    @(posedge clk_in);
    #1;
    clear_start = 1'b0;
    if (exp_ack0) begin
      m_addr = a0; m_data = d0; m_we = 1'b1;
    end else if (exp_ack1) begin
      m_addr = a1; m_data = d1; m_we = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (!r1 || exp_ack1) m_wait = 0;
    else if (exp_ack0) m_wait = m_wait + 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 12'hABC; addr1 = 12'h123;
    data0 = 8'h11; data1 = 8'h22; clear_start = 1'b0;
    #2;
    tests++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      fails++; $display("FAIL reset_acks: got %b%b want 00", ack0, ack1);
    end
    @(posedge clk_in); #1;
    tests++;
    if (ram_address !== 12'h000 || ram_data_out !== 8'h00) begin
      fails++; $display("FAIL reset_ram: got %h/%h want 000/00", ram_address, ram_data_out);
    end
    tests++;
    if (ram_write_enable !== 1'b0 || ram_clk_enable !== 1'b0 || clear_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got we=%b ce=%b busy=%b want 0 0 0",
               ram_write_enable, ram_clk_enable, clear_busy);
    end
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single_write();
    cycle(1'b1, 1'b0, 12'h010, 12'h000, 8'hA5, 8'h00, 1'b0, 1'b0);
    tests++;
    if (obs_ack0 !== 1'b1 || obs_ack1 !== 1'b0) begin
      fails++; $display("FAIL single_ack: got %b%b want 10", obs_ack0, obs_ack1);
    end
    tests++;
    if (ram_address !== 12'h010 || ram_data_out !== 8'hA5) begin
      fails++; $display("FAIL single_ram: got %h/%h want 010/a5", ram_address, ram_data_out);
    end
    tests++;
    if (ram_write_enable !== 1'b1 || ram_clk_enable !== 1'b1) begin
      fails++; $display("FAIL single_we: got %b%b want 11", ram_write_enable, ram_clk_enable);
    end
    cycle(1'b0, 1'b0, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tests++;
    if (ram_write_enable !== 1'b0 || ram_clk_enable !== 1'b0 || ram_address !== 12'h010
        || ram_data_out !== 8'hA5) begin
      fails++;
      $display("FAIL single_hold: got we=%b ce=%b %h/%h want 0 0 010/a5",
               ram_write_enable, ram_clk_enable, ram_address, ram_data_out);
    end
  endtask

  task automatic test_starvation();
    logic want1;
    cycle(1'b0, 1'b0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 27; i++) begin
      want1 = (i % 9 == 8);
      cycle(1'b1, 1'b1, 12'(i), 12'(i + 'h100), 8'(i), 8'(i + 'h80), 1'b0, 1'b0);
      tests++;
      if (obs_ack1 !== want1 || obs_ack0 !== !want1) begin
        fails++;
        $display("FAIL starve_pattern[%0d]: got ack0=%b ack1=%b want %b %b",
                 i, obs_ack0, obs_ack1, !want1, want1);
      end
      tests++;
      if (ram_address !== m_addr || ram_data_out !== m_data || ram_write_enable !== 1'b1) begin
        fails++;
        $display("FAIL starve_ram[%0d]: got %h/%h we=%b want %h/%h we=1",
                 i, ram_address, ram_data_out, ram_write_enable, m_addr, m_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 12'h0, 12'(12'h400 + i), 8'h0, 8'(8'hC0 + i), 1'b0, 1'b0);
      tests++;
      if (obs_ack1 !== 1'b1 || obs_ack0 !== 1'b0) begin
        fails++; $display("FAIL b2b_ack[%0d]: got %b%b want 01", i, obs_ack0, obs_ack1);
      end
      tests++;
      if (ram_address !== 12'(12'h400 + i) || ram_data_out !== 8'(8'hC0 + i)
          || ram_write_enable !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ram[%0d]: got %h/%h we=%b want %h/%h we=1", i, ram_address,
                 ram_data_out, ram_write_enable, 12'(12'h400 + i), 8'(8'hC0 + i));
      end
    end
  endtask

  task automatic test_random();
    logic r0, r1;
    for (int i = 0; i < 400; i++) begin
      // Bias requester 0 high so long contested runs occur.
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      cycle(r0, r1, 12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      tests++;
      if (obs_ack0 !== exp_ack0 || obs_ack1 !== exp_ack1) begin
        fails++;
        $display("FAIL rand_ack[%0d]: got %b%b want %b%b", i, obs_ack0, obs_ack1,
                 exp_ack0, exp_ack1);
      end
      tests++;
      if (ram_address !== m_addr || ram_data_out !== m_data || ram_write_enable !== m_we
          || ram_clk_enable !== m_we) begin
        fails++;
        $display("FAIL rand_ram[%0d]: got %h/%h we=%b ce=%b want %h/%h we=%b", i,
                 ram_address, ram_data_out, ram_write_enable, ram_clk_enable,
                 m_addr, m_data, m_we);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 12'h777, 12'h0, 8'h77, 8'h0, 1'b0, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    #1 reset = 1'b0;
    #1;
    tests++;
    if (ram_address !== 12'h0 || ram_data_out !== 8'h0 || ram_write_enable !== 1'b0
        || ram_clk_enable !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %h/%h we=%b ce=%b ack=%b%b want all 0",
               ram_address, ram_data_out, ram_write_enable, ram_clk_enable, ack0, ack1);
    end
    @(posedge clk_in); #1;
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 12'h0, 12'h321, 8'h0, 8'h32, 1'b0, 1'b0);
    tests++;
    if (obs_ack1 !== 1'b1 || ram_address !== 12'h321 || ram_data_out !== 8'h32) begin
      fails++;
      $display("FAIL async_reset_after: got ack1=%b %h/%h want 1 321/32",
               obs_ack1, ram_address, ram_data_out);
    end
  endtask

`ifdef FB_CLEAR_EN
  // Runs clear cycles 0..n-1, checking busy, blocked acks and the zero write
  // of address k showing up on the RAM drive the cycle after clear cycle k.
  // A second clear_start is pulsed at clear address 'repulse' (use -1 for none).
  task automatic run_clear(input int n, input int repulse, input string tag);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b1, 12'hAAA, 12'hBBB, 8'hAA, 8'hBB, 1'(k == repulse), 1'b1);
      m_addr = 12'(k); m_data = 8'h00; m_we = 1'b1;
      tests++;
      if (obs_busy !== 1'b1 || obs_ack0 !== 1'b0 || obs_ack1 !== 1'b0) begin
        fails++;
        $display("FAIL %s_busy[%0d]: got busy=%b ack=%b%b want 1 00", tag, k, obs_busy,
                 obs_ack0, obs_ack1);
      end
      tests++;
      if (ram_address !== m_addr || ram_data_out !== 8'h00 || ram_write_enable !== 1'b1) begin
        fails++;
        $display("FAIL %s_write[%0d]: got %h/%h we=%b want %h/00 we=1", tag, k,
                 ram_address, ram_data_out, ram_write_enable, m_addr);
      end
    end
  endtask

  task automatic test_clear();
    cycle(1'b0, 1'b0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 12'h123, 12'h0, 8'h5A, 8'h0, 1'b1, 1'b0);
    tests++;
    if (obs_ack0 !== 1'b1 || obs_busy !== 1'b0 || ram_address !== 12'h123
        || ram_data_out !== 8'h5A) begin
      fails++;
      $display("FAIL clear_start_xfer: got ack0=%b busy=%b %h/%h want 1 0 123/5a",
               obs_ack0, obs_busy, ram_address, ram_data_out);
    end
    run_clear(4096, -1, "clear");
    cycle(1'b1, 1'b0, 12'h3C3, 12'h0, 8'h3C, 8'h0, 1'b0, 1'b0);
    tests++;
    if (obs_busy !== 1'b0 || obs_ack0 !== 1'b1 || ram_address !== 12'h3C3) begin
      fails++;
      $display("FAIL clear_end: got busy=%b ack0=%b addr=%h want 0 1 3c3",
               obs_busy, obs_ack0, ram_address);
    end
  endtask

  task automatic test_clear_restart();
    cycle(1'b0, 1'b0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b1, 1'b0);
    run_clear(4096, 'h800, "restart");
    cycle(1'b0, 1'b0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    tests++;
    if (obs_busy !== 1'b0 || ram_write_enable !== 1'b0) begin
      fails++;
      $display("FAIL restart_end: got busy=%b we=%b want 0 0", obs_busy, ram_write_enable);
    end
  endtask

  task automatic test_reset_mid_clear();
    cycle(1'b0, 1'b0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b1, 1'b0);
    run_clear('h100, -1, "rstclr");
    req0 = 1'b1; req1 = 1'b1;
    #1 reset = 1'b0;
    #1;
    tests++;
    if (ram_address !== 12'h0 || ram_data_out !== 8'h0 || ram_write_enable !== 1'b0
        || ram_clk_enable !== 1'b0 || clear_busy !== 1'b0 || ack0 !== 1'b0
        || ack1 !== 1'b0) begin
      fails++;
      $display("FAIL rstclr_outputs: got %h/%h we=%b ce=%b busy=%b ack=%b%b want all 0",
               ram_address, ram_data_out, ram_write_enable, ram_clk_enable, clear_busy,
               ack0, ack1);
    end
    @(posedge clk_in); #1;
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 12'h0, 12'h654, 8'h0, 8'h65, 1'b0, 1'b0);
    tests++;
    if (obs_ack1 !== 1'b1 || obs_busy !== 1'b0 || ram_address !== 12'h654) begin
      fails++;
      $display("FAIL rstclr_after: got ack1=%b busy=%b addr=%h want 1 0 654",
               obs_ack1, obs_busy, ram_address);
    end
    cycle(1'b0, 1'b0, 12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    tests++;
    if (obs_busy !== 1'b0 || ram_write_enable !== 1'b0) begin
      fails++;
      $display("FAIL rstclr_idle: got busy=%b we=%b want 0 0", obs_busy, ram_write_enable);
    end
  endtask
`else
  task automatic test_clear_disabled();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 12'(12'h500 + i), 12'h0, 8'(i), 8'h0, 1'(i == 0 || i == 7), 1'b0);
      tests++;
      if (obs_busy !== 1'b0 || obs_ack0 !== 1'b1) begin
        fails++;
        $display("FAIL noclear[%0d]: got busy=%b ack0=%b want 0 1", i, obs_busy, obs_ack0);
      end
      tests++;
      if (ram_address !== m_addr || ram_data_out !== m_data || ram_write_enable !== 1'b1) begin
        fails++;
        $display("FAIL noclear_ram[%0d]: got %h/%h we=%b want %h/%h we=1", i, ram_address,
                 ram_data_out, ram_write_enable, m_addr, m_data);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_starvation();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef FB_CLEAR_EN
    test_clear();
    test_clear_restart();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, framebuffer port-A address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, framebuffer port-A data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4'd8, the maximum number of consecutive requester-0 grants while requester 1 is pending.
REQ-004 SHALL have port clk_in, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-006 SHALL have ports req0 / req1, input, 1 each, write request from the control module (0) and the secondary writer (1).
REQ-007 SHALL have ports addr0 / addr1, input, ADDR_WIDTH each, and data0 / data1, input, DATA_WIDTH each, the write payloads.
REQ-008 SHALL have ports ack0 / ack1, output, 1 each, combinational accept; transfer occurs when reqN and ackN are both high in the same cycle.
REQ-009 SHALL have port clear_start, input, 1, single-cycle pulse requesting a full framebuffer clear.
REQ-010 SHALL have port clear_busy, output, 1, high while the clear sequence runs.
REQ-011 SHALL have ports ram_address (output, ADDR_WIDTH), ram_data_out (output, DATA_WIDTH), ram_write_enable (output, 1) and ram_clk_enable (output, 1), the registered port-A drive.

Function
REQ-012 SHALL implement FSM states IDLE and CLEAR.
REQ-013 SHALL grant at most one transfer per cycle.
REQ-014 In IDLE, SHALL use fixed priority req0 over req1, except as overridden by REQ-015.
REQ-015 SHALL count consecutive req0 grants made while req1 is high; when the count equals STARVE_LIMIT and both requests are high, SHALL grant req1 and clear the count.
REQ-016 SHALL also clear the starvation count on any req1 grant or on any cycle with req1 low.
REQ-017 SHALL register the accepted address and data into ram_address / ram_data_out and assert ram_write_enable = ram_clk_enable = 1 in the cycle after the transfer, giving a latency of exactly 1.
REQ-018 With no transfer, SHALL drive ram_write_enable and ram_clk_enable to 0 and hold ram_address / ram_data_out.
REQ-019 SHALL enter CLEAR on clear_start in IDLE; a same-cycle requester transfer still completes, and the clear begins the next cycle.
REQ-020 In CLEAR, SHALL hold ack0 = ack1 = 0 and write 0 to addresses 0 through 2^ADDR_WIDTH-1, one per cycle, in ascending order.
REQ-021 SHALL keep clear_busy high from the cycle after clear_start through the cycle of the final write, then return to IDLE.
REQ-022 SHALL ignore clear_start while in CLEAR, without restarting or extending the clear.
REQ-023 SHALL let the clear address counter terminate on all-ones without wrapping to a second pass.
REQ-024 SHALL never drop a request: reqN held high with stable payload is eventually acked, at the latest after STARVE_LIMIT+1 cycles plus any clear.

Reset
REQ-025 While reset is low, SHALL set FSM = IDLE, starvation count = 0, clear counter = 0, ram_address = 0, ram_data_out = 0, ram_write_enable = 0, ram_clk_enable = 0 and clear_busy = 0.
REQ-026 While reset is low, SHALL hold ack0 = ack1 = 0.
REQ-027 Reset asserted mid-clear SHALL abort the clear; after release, the block SHALL be in IDLE with no pending clear.

Configuration
REQ-028 With macro FB_CLEAR_EN defined, SHALL include the CLEAR state, the clear counter and the behaviour of clear_start / clear_busy.
REQ-029 Without FB_CLEAR_EN, SHALL keep the clear_start / clear_busy ports, ignore clear_start, tie clear_busy to 0, and never leave IDLE.

Verification
REQ-030 SHALL cover: req0 = 1 with addr0 = 12'h010, data0 = 8'hA5 -> ack0 = 1 the same cycle, then the next cycle ram_address = 12'h010, ram_data_out = 8'hA5, ram_write_enable = 1.
REQ-031 SHALL cover: req0 and req1 held high continuously, STARVE_LIMIT = 8 -> grant pattern of 8 ack0 then 1 ack1, repeating.
REQ-032 SHALL cover (FB_CLEAR_EN defined): clear_start pulse -> clear_busy high for 4096 cycles, writes of 0 to 0x000 through 0xFFF in order, ack0 = ack1 = 0 throughout, and req0 acked on the first cycle after clear_busy falls.
REQ-033 SHALL cover: clear_start pulsed again at clear address 0x800 -> no restart, with clear_busy falling after write 0xFFF.
REQ-034 SHALL cover: reset driven low at clear address 0x100 -> all outputs 0 immediately; after release, IDLE with req1 acked on its first request.
REQ-035 SHALL cover (FB_CLEAR_EN undefined): clear_start pulse -> clear_busy stays 0 and req0 continues to be acked every cycle.
